keycode_report_rx: RTL and testbench

KEYCODE_REPORT_RX -- requirements
Module: keycode_report_rx

---
 rtl/keycode_report_rx.sv | 130 +++++++++++++
 tb/tb_keycode_report_rx.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keycode_report_rx.sv
// Receives 8-byte HID keyboard reports; outputs update 2 edges after the final byte, and only for clean reports.
// rx_ready drops only for the single COMMIT cycle. Malformed, timed-out or rollover reports pulse report_error.
module keycode_report_rx #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [7:0]  ROLLOVER_CODE  = 8'h01
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_last,
  output logic       rx_ready,
  output logic [7:0] keycode0,
  output logic [7:0] keycode1,
  output logic [7:0] modifiers,
  output logic       report_valid,
  output logic       key_change,
  output logic       report_error
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, COMMIT} state_t;

  state_t      state;
  logic [2:0]  byte_idx;
  logic [15:0] gap_cnt;
  logic [7:0]  shadow_mod;
  logic [7:0]  shadow_k0;
  logic [7:0]  shadow_k1;

  logic        accept;
  logic [15:0] gap_nxt;
  logic        timeout_hit;

  assign accept      = rx_valid && rx_ready;
  assign gap_nxt     = gap_cnt + 16'd1;
  // The report is abandoned at the edge where the idle count reaches the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) && (gap_nxt == TIMEOUT_CYCLES);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      byte_idx     <= 3'd0;
      gap_cnt      <= 16'd0;
      shadow_mod   <= 8'h00;
      shadow_k0    <= 8'h00;
      shadow_k1    <= 8'h00;
      rx_ready     <= 1'b1;
      keycode0     <= 8'h00;
      keycode1     <= 8'h00;
      modifiers    <= 8'h00;
      report_valid <= 1'b0;
      key_change   <= 1'b0;
      report_error <= 1'b0;
    end else begin
      report_valid <= 1'b0;
      key_change   <= 1'b0;
      report_error <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            shadow_mod <= rx_data;
            gap_cnt    <= 16'd0;
            if (rx_last) begin
              report_error <= 1'b1;
              byte_idx     <= 3'd0;
            end else begin
              byte_idx <= 3'd1;
              state    <= RECV;
            end
          end
        end

        RECV, DRAIN: begin
          if (accept) begin
            gap_cnt  <= 16'd0;
            byte_idx <= byte_idx + 3'd1;
            if (state == RECV) begin
              if (byte_idx == 3'd2) shadow_k0 <= rx_data;
              if (byte_idx == 3'd3) shadow_k1 <= rx_data;
              if (byte_idx == 3'd7) begin
                if (rx_last) begin
                  state    <= COMMIT;
                  rx_ready <= 1'b0;
                end else begin
                  report_error <= 1'b1;
                  state        <= DRAIN;
                end
              end else if (rx_last) begin
                report_error <= 1'b1;
                state        <= IDLE;
                byte_idx     <= 3'd0;
              end
            end else if (rx_last) begin
              state    <= IDLE;
              byte_idx <= 3'd0;
            end
          end else if (timeout_hit) begin
            report_error <= 1'b1;
            state        <= IDLE;
            byte_idx     <= 3'd0;
            gap_cnt      <= 16'd0;
          end else begin
            gap_cnt <= gap_nxt;
          end
        end

        COMMIT: begin
          // A rollover report carries no usable key data, so the last good report persists.
          if (shadow_k0 == ROLLOVER_CODE) begin
            report_error <= 1'b1;
          end else begin
            keycode0     <= shadow_k0;
            keycode1     <= shadow_k1;
            modifiers    <= shadow_mod;
            report_valid <= 1'b1;
            key_change   <= (shadow_k0 != keycode0) || (shadow_k1 != keycode1);
          end
          state    <= IDLE;
          rx_ready <= 1'b1;
          byte_idx <= 3'd0;
          gap_cnt  <= 16'd0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keycode_report_rx.sv
// Bench for keycode_report_rx: scoreboard of expected committed reports plus per-scenario inline checks.
module tb_keycode_report_rx;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic       rx_ready;
  logic [7:0] keycode0;
  logic [7:0] keycode1;
  logic [7:0] modifiers;
  logic       report_valid;
  logic       key_change;
  logic       report_error;

  keycode_report_rx #(
    .TIMEOUT_CYCLES(16'd8),
    .ROLLOVER_CODE (8'h01)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_last     (rx_last),
    .rx_ready    (rx_ready),
    .keycode0    (keycode0),
    .keycode1    (keycode1),
    .modifiers   (modifiers),
    .report_valid(report_valid),
    .key_change  (key_change),
    .report_error(report_error)
  );

  initial forever #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] k0;
    logic [7:0] k1;
    logic [7:0] md;
    logic       kc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         err_seen = 0;
  logic [7:0] m_k0 = 8'h00;
  logic [7:0] m_k1 = 8'h00;
  logic [7:0] m_md = 8'h00;

  // Commit monitor: every report_valid pulse must match the oldest expected report.
  always @(negedge Clk) begin
    if (report_error) err_seen++;
    if (key_change && !report_valid) begin
      checks++; errors++;
      $display("FAIL key_change_alone got key_change=1 report_valid=0 want both or neither");
    end
    if (report_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit got k0=%h k1=%h md=%h want no commit", keycode0, keycode1, modifiers);
      end else begin
        mon_e = sb.pop_front();
        if ({keycode0, keycode1, modifiers, key_change} !== mon_e) begin
          errors++;
          $display("FAIL commit_data got k0=%h k1=%h md=%h kc=%b want k0=%h k1=%h md=%h kc=%b",
                   keycode0, keycode1, modifiers, key_change, mon_e.k0, mon_e.k1, mon_e.md, mon_e.kc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int w;
    w = 0;
    rx_data  = d;
    rx_last  = l;
    rx_valid = 1'b1;
    while (!rx_ready && w < 20) begin
      @(posedge Clk); #1;
      w++;
    end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL rx_ready_wait got rx_ready=0 after %0d cycles want 1", w);
    end
    @(posedge Clk); #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic send_stream(input int n, input logic [7:0] md, input logic [7:0] k0,
                             input logic [7:0] k1, output int err_at);
    logic [7:0] b;
    err_at = -1;
    for (int i = 0; i < n; i++) begin
      case (i)
        0:       b = md;
        2:       b = k0;
        3:       b = k1;
        default: b = 8'hA0 + 8'(i);
      endcase
      send_byte(b, i == n - 1);
      if (report_error && err_at < 0) err_at = i;
    end
  endtask

  task automatic expect_commit(input logic [7:0] md, input logic [7:0] k0, input logic [7:0] k1);
    exp_t e;
    e.k0 = k0;
    e.k1 = k1;
    e.md = md;
    e.kc = (k0 != m_k0) || (k1 != m_k1);
    sb.push_back(e);
    m_k0 = k0;
    m_k1 = k1;
    m_md = md;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    #1;
    checks++;
    if ({keycode0, keycode1, modifiers, report_valid, key_change, report_error, rx_ready} !== {24'h0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_async got k0=%h k1=%h md=%h rv=%b kc=%b re=%b rdy=%b want zeros rdy=1",
               keycode0, keycode1, modifiers, report_valid, key_change, report_error, rx_ready);
    end
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    checks++;
    if ({keycode0, keycode1, modifiers, report_valid, key_change, report_error, rx_ready} !== {24'h0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_release got k0=%h k1=%h md=%h rv=%b kc=%b re=%b rdy=%b want zeros rdy=1",
               keycode0, keycode1, modifiers, report_valid, key_change, report_error, rx_ready);
    end
  endtask

  task automatic test_clean;
    int ea;
    expect_commit(8'h00, 8'h07, 8'h00);
    send_stream(8, 8'h00, 8'h07, 8'h00, ea);
    checks++;
    if (ea != -1) begin errors++; $display("FAIL clean_no_error got err_at=%0d want -1", ea); end
    checks++;
    if (keycode0 !== 8'h00 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL clean_latency_one_edge got k0=%h rdy=%b want k0=00 rdy=0", keycode0, rx_ready);
    end
    @(posedge Clk); #1;
    checks++;
    if ({keycode0, keycode1, report_valid, key_change} !== {8'h07, 8'h00, 2'b11}) begin
      errors++;
      $display("FAIL clean_commit got k0=%h k1=%h rv=%b kc=%b want 07 00 1 1",
               keycode0, keycode1, report_valid, key_change);
    end
    @(posedge Clk); #1;
    checks++;
    if (report_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL clean_pulse_width got rv=%b pending=%0d want 0 0", report_valid, sb.size());
    end
  endtask

  task automatic test_repeat;
    int ea;
    expect_commit(8'h00, 8'h07, 8'h00);
    send_stream(8, 8'h00, 8'h07, 8'h00, ea);
    @(posedge Clk); #1;
    checks++;
    if (report_valid !== 1'b1 || key_change !== 1'b0) begin
      errors++;
      $display("FAIL repeat_no_change got rv=%b kc=%b want 1 0", report_valid, key_change);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_early_end;
    int ea;
    int e0;
    e0 = err_seen;
    send_stream(5, 8'h00, 8'h04, 8'h07, ea);
    checks++;
    if (ea != 4) begin errors++; $display("FAIL early_end_timing got err_at=%0d want 4", ea); end
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (err_seen - e0 != 1 || keycode0 !== 8'h07) begin
      errors++;
      $display("FAIL early_end_hold got pulses=%0d k0=%h want 1 07", err_seen - e0, keycode0);
    end
    send_stream(1, 8'h55, 8'h00, 8'h00, ea);
    checks++;
    if (ea != 0) begin errors++; $display("FAIL idle_last_error got err_at=%0d want 0", ea); end
    expect_commit(8'h02, 8'h04, 8'h07);
    send_stream(8, 8'h02, 8'h04, 8'h07, ea);
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if ({keycode0, keycode1, modifiers} !== {8'h04, 8'h07, 8'h02} || sb.size() != 0) begin
      errors++;
      $display("FAIL recover_commit got k0=%h k1=%h md=%h pending=%0d want 04 07 02 0",
               keycode0, keycode1, modifiers, sb.size());
    end
  endtask

  task automatic test_overlong;
    int ea;
    int e0;
    e0 = err_seen;
    send_stream(10, 8'h11, 8'h05, 8'h06, ea);
    checks++;
    if (ea != 7) begin errors++; $display("FAIL overlong_timing got err_at=%0d want 7", ea); end
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (err_seen - e0 != 1 || {keycode0, keycode1, modifiers} !== {8'h04, 8'h07, 8'h02} || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL overlong_drain got pulses=%0d k0=%h k1=%h md=%h rdy=%b want 1 04 07 02 1",
               err_seen - e0, keycode0, keycode1, modifiers, rx_ready);
    end
  endtask

  task automatic test_rollover;
    int ea;
    int e0;
    e0 = err_seen;
    send_stream(8, 8'h22, 8'h01, 8'h09, ea);
    @(posedge Clk); #1;
    checks++;
    if ({report_error, report_valid, keycode0, keycode1, modifiers} !== {2'b10, 8'h04, 8'h07, 8'h02}) begin
      errors++;
      $display("FAIL rollover got re=%b rv=%b k0=%h k1=%h md=%h want 1 0 04 07 02",
               report_error, report_valid, keycode0, keycode1, modifiers);
    end
    @(posedge Clk); #1;
    checks++;
    if (err_seen - e0 != 1) begin errors++; $display("FAIL rollover_pulses got %0d want 1", err_seen - e0); end
  endtask

  task automatic test_back_to_back;
    int ea;
    expect_commit(8'h00, 8'h05, 8'h06);
    send_stream(8, 8'h00, 8'h05, 8'h06, ea);
    expect_commit(8'h01, 8'h05, 8'h08);
    send_stream(8, 8'h01, 8'h05, 8'h08, ea);
    expect_commit(8'h03, 8'h05, 8'h08);
    send_stream(8, 8'h03, 8'h05, 8'h08, ea);
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (sb.size() != 0 || {keycode0, keycode1, modifiers} !== {8'h05, 8'h08, 8'h03}) begin
      errors++;
      $display("FAIL back_to_back got pending=%0d k0=%h k1=%h md=%h want 0 05 08 03",
               sb.size(), keycode0, keycode1, modifiers);
    end
  endtask

  task automatic test_timeout_reset;
    int ea;
    int e1;
    send_byte(8'h44, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0B, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk); #1;
      checks++;
      if (report_error !== (k == 8)) begin
        errors++;
        $display("FAIL timeout_idle_%0d got re=%b want %b", k, report_error, (k == 8));
      end
    end
    checks++;
    if ({keycode0, keycode1, modifiers} !== {8'h05, 8'h08, 8'h03} || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold got k0=%h k1=%h md=%h rdy=%b want 05 08 03 1",
               keycode0, keycode1, modifiers, rx_ready);
    end
    send_byte(8'h33, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'h04, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({keycode0, keycode1, modifiers, report_valid, key_change, report_error, rx_ready} !== {24'h0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_mid_report got k0=%h k1=%h md=%h rv=%b kc=%b re=%b rdy=%b want zeros rdy=1",
               keycode0, keycode1, modifiers, report_valid, key_change, report_error, rx_ready);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    m_k0 = 8'h00;
    m_k1 = 8'h00;
    m_md = 8'h00;
    e1 = err_seen;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if (err_seen != e1) begin errors++; $display("FAIL reset_no_error got pulses=%0d want 0", err_seen - e1); end
    expect_commit(8'h00, 8'h07, 8'h00);
    send_stream(8, 8'h00, 8'h07, 8'h00, ea);
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (sb.size() != 0 || keycode0 !== 8'h07 || ea != -1) begin
      errors++;
      $display("FAIL post_reset_commit got pending=%0d k0=%h err_at=%0d want 0 07 -1", sb.size(), keycode0, ea);
    end
  endtask

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_last  = 1'b0;
    test_reset;
    test_clean;
    test_repeat;
    test_early_end;
    test_overlong;
    test_rollover;
    test_back_to_back;
    test_timeout_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
